// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART transmit feeder slice.
//   feeder_state_t : launch FSM states (GAP exists only when the design is
//                    built with UART_TX_FEEDER_GAP_EN)
//   DEF_*          : default parameter values
//   count_w()      : width of a FIFO occupancy count for a given depth
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_GAP_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } feeder_state_t;

    // Occupancy runs 0..depth inclusive, so it needs one bit more than the index.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with wrap-bit pointers and a registered full flag.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and data (ignored while full)
//   pop               : read request (ignored while empty)
//   flush             : synchronous clear of both pointers; beats push/pop
//   head              : entry at the read pointer
//   full, empty       : status; full is a flop loaded from next-state pointers
//   count             : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [AW:0]       wr_ptr_n, rd_ptr_n;
    logic              full_q;
    logic              do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end else begin
            if (do_push) wr_ptr_n = wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr_n = rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full_q <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            // Same index, different lap: the writer is a whole buffer ahead.
            full_q <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
        end
    end

    // Storage has no reset; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign full  = full_q;
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Buffers host bytes and launches them one at a time into uart_trans, waiting
// for TX_Done between launches.
// Build option: define UART_TX_FEEDER_GAP_EN to compile in a GAP state that
// holds off the next launch for GAP_CYCLES clocks after every TX_Done.
// Ports:
//   clk, rst_n          : clock shared with uart_trans, async active-low reset
//   in_valid, in_data   : host byte stream
//   in_ready            : registered, high while the FIFO is not full
//   flush               : synchronous FIFO clear; an in-flight frame completes
//   TX_DV, TX_BYTE      : one-cycle launch strobe and held byte to uart_trans
//   TX_Active           : transmitter busy, status only
//   TX_Done             : transmitter end-of-frame pulse
//   fifo_count          : current FIFO occupancy
//   busy                : FSM not IDLE or FIFO not empty
// Handshake: a byte transfers on every rising clk edge where in_valid and
// in_ready are both high; in_valid may rise without waiting for in_ready, and
// in_ready never depends combinationally on in_valid.
// -----------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     TX_DV,
    output logic [DATA_W-1:0]        TX_BYTE,
    input  logic                     TX_Active,
    input  logic                     TX_Done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    feeder_state_t     state_q, state_n;
    logic              launch;
    logic              tx_dv_q;
    logic [DATA_W-1:0] tx_byte_q;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (launch),
        .flush     (flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef UART_TX_FEEDER_GAP_EN
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GW-1:0] gap_cnt_q, gap_cnt_n;
`else
    logic unused_gap;
    assign unused_gap = (GAP_CYCLES != 0);
`endif

    // Transmitter activity is informational; launches are paced by TX_Done.
    logic unused_tx_active;
    assign unused_tx_active = TX_Active;

    always_comb begin
        state_n = state_q;
        launch  = 1'b0;
`ifdef UART_TX_FEEDER_GAP_EN
        gap_cnt_n = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    launch  = 1'b1;
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (TX_Done) begin
`ifdef UART_TX_FEEDER_GAP_EN
                    state_n   = GAP;
                    gap_cnt_n = GW'(GAP_CYCLES - 1);
`else
                    state_n   = IDLE;
`endif
                end
            end
`ifdef UART_TX_FEEDER_GAP_EN
            GAP: begin
                if (gap_cnt_q == '0) state_n = IDLE;
                else                 gap_cnt_n = gap_cnt_q - GW'(1);
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
`ifdef UART_TX_FEEDER_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_n;
            tx_dv_q <= launch;
            if (launch) tx_byte_q <= fifo_head;
`ifdef UART_TX_FEEDER_GAP_EN
            gap_cnt_q <= gap_cnt_n;
`endif
        end
    end

    assign in_ready = !fifo_full;
    assign TX_DV    = tx_dv_q;
    assign TX_BYTE  = tx_byte_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
// Directed bench for uart_tx_feeder. Bytes that must be launched are queued in
// exp_q when the host handshake completes; a negedge monitor pops and compares
// on every TX_DV, and also checks launch ordering against TX_Done and the
// launch-to-launch spacing while spacing_chk is set.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 16;
    localparam int GAP_CYCLES = 16;
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam int FRAME_LEN  = 12;
`ifdef UART_TX_FEEDER_GAP_EN
    localparam int EXP_GAP = GAP_CYCLES + 1;
`else
    localparam int EXP_GAP = 1;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              TX_DV;
    logic [DATA_W-1:0] TX_BYTE;
    logic              TX_Active;
    logic              TX_Done;
    logic [CW-1:0]     fifo_count;
    logic              busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_feeder #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .TX_DV      (TX_DV),
        .TX_BYTE    (TX_BYTE),
        .TX_Active  (TX_Active),
        .TX_Done    (TX_Done),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    // ---------------- scoreboard state ----------------
    int                compared   = 0;
    int                mismatched = 0;
    logic [DATA_W-1:0] exp_q[$];
    bit                outstanding = 1'b0;
    bit                done_valid  = 1'b0;
    bit                spacing_chk = 1'b0;
    int                done_cyc    = 0;
    int                launches    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 1'b0;
            done_valid  = 1'b0;
        end else begin
            if (TX_DV) begin
                launches++;
                chk("launch_after_done", outstanding, 0);
                chk("launch_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("launch_byte", TX_BYTE, exp_q.pop_front());
                if (spacing_chk && done_valid) chk("launch_spacing", cyc - done_cyc, EXP_GAP);
                outstanding = 1'b1;
                done_valid  = 1'b0;
            end
            if (TX_Done && outstanding) begin
                outstanding = 1'b0;
                done_valid  = 1'b1;
                done_cyc    = cyc + 1;   // edge that samples this TX_Done
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so consecutive calls give back-to-back pushes.
    task automatic push(input logic [DATA_W-1:0] d, input bit exp_launch);
        bit acc;
        int g = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            acc = in_ready;
            tick();
            g++;
        end while (!acc && g < 100);
        chk("push_accepted", acc, 1);
        if (acc && exp_launch) exp_q.push_back(d);
    endtask

    task automatic wait_dv();
        int g = 0;
        while (!TX_DV && g < 300) begin
            tick();
            g++;
        end
        chk("launch_seen", TX_DV, 1);
        TX_Active = 1'b1;
    endtask

    task automatic finish_frame();
        repeat (FRAME_LEN) tick();
        TX_Done   = 1'b1;
        TX_Active = 1'b0;
        tick();
        TX_Done   = 1'b0;
    endtask

    task automatic serve();
        wait_dv();
        finish_frame();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tx_dv"},      TX_DV, 0);
        chk({tag, "_tx_byte"},    TX_BYTE, 0);
        chk({tag, "_in_ready"},   in_ready, 1);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_busy"},       busy, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        TX_Active = 1'b0;
        TX_Done   = 1'b0;
        repeat (3) tick();
        check_reset_vals("in_reset");
        rst_n = 1'b1;
        tick();
        check_reset_vals("after_reset");

        // Single byte: launch one clock after acceptance.
        push(8'hA5, 1'b1);
        in_valid = 1'b0;
        chk("count_after_push", fifo_count, 1);
        chk("ready_after_push", in_ready, 1);
        tick();
        chk("dv_latency", TX_DV, 1);
        chk("byte_latency", TX_BYTE, 8'hA5);
        chk("busy_in_frame", busy, 1);
        TX_Active = 1'b1;
        tick();
        chk("dv_one_cycle", TX_DV, 0);
        chk("byte_held", TX_BYTE, 8'hA5);

        // Burst of 16 while 0xA5 is still in flight fills the FIFO.
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        in_valid = 1'b0;
        chk("full_ready", in_ready, 0);
        chk("full_count", fifo_count, 16);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("overflow_count", fifo_count, 16);
        chk("overflow_ready", in_ready, 0);

        spacing_chk = 1'b1;
        finish_frame();              // 0xA5 done
        wait_dv();                   // 0x00 launched
        chk("pop_count", fifo_count, 15);
        chk("pop_ready", in_ready, 1);

        // Push lands on the same edge as the next launch: occupancy unchanged.
        repeat (FRAME_LEN) tick();
        TX_Done   = 1'b1;
        TX_Active = 1'b0;
        tick();
        TX_Done   = 1'b0;
        repeat (EXP_GAP - 1) tick();
        in_valid = 1'b1;
        in_data  = 8'h10;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(8'h10);
        chk("same_cycle_count", fifo_count, 15);
        chk("same_cycle_dv", TX_DV, 1);
        TX_Active = 1'b1;
        finish_frame();              // 0x01 done
        repeat (15) serve();         // 0x02..0x0F, 0x10
        spacing_chk = 1'b0;
        repeat (EXP_GAP + 1) tick();
        chk("drained_busy", busy, 0);
        chk("drained_count", fifo_count, 0);
        chk("launch_total_burst", launches, 18);

        // Flush during frame 3 of 8; a same-cycle push is dropped too.
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i), (i < 3));
        in_valid = 1'b0;
        chk("flush_pre_count", fifo_count, 7);
        TX_Active = 1'b1;
        finish_frame();              // 0x20
        serve();                     // 0x21
        wait_dv();                   // 0x22 in flight
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", fifo_count, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_busy", busy, 1);
        finish_frame();
        repeat (40) tick();
        chk("post_flush_busy", busy, 0);
        chk("post_flush_launches", launches, 21);

        // Reset mid-frame with five bytes queued, then a stray TX_Done.
        for (int i = 0; i < 6; i++) push(8'(8'h30 + i), (i == 0));
        in_valid = 1'b0;
        chk("queued_count", fifo_count, 5);
        TX_Active = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        TX_Done   = 1'b1;
        TX_Active = 1'b0;
        tick();
        TX_Done = 1'b0;
        repeat (30) tick();
        check_reset_vals("post_reset");
        chk("post_reset_launches", launches, 22);

        // Fresh push after reset is launched normally.
        push(8'h42, 1'b1);
        in_valid = 1'b0;
        serve();
        repeat (EXP_GAP + 2) tick();
        chk("queue_empty", exp_q.size(), 0);
        chk("launch_total", launches, 23);
        chk("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
